// File: rtl/fetch_pkg.sv
// Instruction word width, IR field positions and the packed IR layout shared by the fetch front end.
package fetch_pkg;
  localparam int INST_W = 16;

  localparam int OP_MSB       = 15;
  localparam int OP_LSB       = 11;
  localparam int RS_MSB       = 10;
  localparam int RS_LSB       = 8;
  localparam int RT_MSB       = 7;
  localparam int RT_LSB       = 5;
  localparam int RD_MSB       = 4;
  localparam int RD_LSB       = 2;
  localparam int FUNCT_MSB    = 1;
  localparam int FUNCT_LSB    = 0;
  localparam int IMM_MSB      = 4;
  localparam int IMM_LSB      = 0;
  localparam int LONG_IMM_MSB = 7;
  localparam int LONG_IMM_LSB = 0;
  localparam int ADDRESS_MSB  = 10;
  localparam int ADDRESS_LSB  = 0;

  // R-type view of the IR; the immediate/address views overlap it and are sliced from the raw word.
  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]       op;
    logic [RS_MSB-RS_LSB:0]       rs;
    logic [RT_MSB-RT_LSB:0]       rt;
    logic [RD_MSB-RD_LSB:0]       rd;
    logic [FUNCT_MSB-FUNCT_LSB:0] funct;
  } ir_fields_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for prefetched instruction words; a pushed word is poppable the next cycle.
// Push is ignored when full and pop is ignored when empty; clear empties the queue on the next edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = INST_W,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps DEPTH=1 legal, where the pointer must stay at 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_ir_unit.sv
// Fetch front end: prefetch queue, IR with field decode, architectural PC and fetch-address counter.
// Fields valid two cycles after a push; mem_ready comes from registered occupancy only and drops during flush.
module fetch_ir_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter int                ADDR_W   = 16,
  parameter int                PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] fetch_pc,
  input  logic              ir_write,
  input  logic              flush,
  input  logic              pc_write,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              ir_stall,
  output logic [4:0]        op,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [2:0]        rd,
  output logic [1:0]        funct,
  output logic [4:0]        imm,
  output logic [7:0]        long_imm,
  output logic [10:0]       address
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [INST_W-1:0] q_head;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic              push;
  logic              pop;
  ir_fields_t        ir;
  logic [INST_W-1:0] ir_word;

  assign mem_ready = (q_count < CNT_W'(DEPTH)) && !flush;
  assign push      = mem_valid && !q_full && !flush;
  assign pop       = ir_write && !q_empty && !flush;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (mem_data),
    .pop       (pop),
    .clear     (flush),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      ir_stall <= 1'b0;
    end else begin
      if (pc_write) pc <= pc_next;
      if (flush) begin
        // Redirect to the PC the datapath is committing this cycle, not the stale one.
        fetch_pc <= pc_write ? pc_next : pc;
        ir_valid <= 1'b0;
      end else begin
        if (push) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (ir_write) begin
          if (!q_empty) begin
            ir       <= ir_fields_t'(q_head);
            ir_valid <= 1'b1;
            ir_stall <= 1'b0;
          end else begin
            ir_stall <= 1'b1;
          end
        end
      end
    end
  end

  assign ir_word  = ir;
  assign op       = ir.op;
  assign rs       = ir.rs;
  assign rt       = ir.rt;
  assign rd       = ir.rd;
  assign funct    = ir.funct;
  assign imm      = ir_word[IMM_MSB:IMM_LSB];
  assign long_imm = ir_word[LONG_IMM_MSB:LONG_IMM_LSB];
  assign address  = ir_word[ADDRESS_MSB:ADDRESS_LSB];
endmodule

// File: tb/tb_fetch_ir_unit.sv
// Directed then random stimulus against a queue-based reference model of the fetch front end.
module tb_fetch_ir_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic [15:0] fetch_pc;
  logic        ir_write;
  logic        flush;
  logic        pc_write;
  logic [15:0] pc_next;
  logic [15:0] pc;
  logic        ir_valid;
  logic        ir_stall;
  logic [4:0]  op;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  rd;
  logic [1:0]  funct;
  logic [4:0]  imm;
  logic [7:0]  long_imm;
  logic [10:0] address;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  logic [15:0] m_pc;
  logic [15:0] m_fpc;
  logic [15:0] m_ir;
  logic        m_irv;
  logic        m_stall;

  fetch_ir_unit #(
    .DEPTH    (DEPTH),
    .ADDR_W   (16),
    .PC_STEP  (1),
    .RESET_PC (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .fetch_pc  (fetch_pc),
    .ir_write  (ir_write),
    .flush     (flush),
    .pc_write  (pc_write),
    .pc_next   (pc_next),
    .pc        (pc),
    .ir_valid  (ir_valid),
    .ir_stall  (ir_stall),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .funct     (funct),
    .imm       (imm),
    .long_imm  (long_imm),
    .address   (address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = 16'h0000;
    m_fpc   = 16'h0000;
    m_ir    = 16'h0000;
    m_irv   = 1'b0;
    m_stall = 1'b0;
  endtask

  task automatic check_state();
    chk("pc",       32'(pc),       32'(m_pc));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
    chk("ir_valid", 32'(ir_valid), 32'(m_irv));
    chk("ir_stall", 32'(ir_stall), 32'(m_stall));
    chk("op",       32'(op),       32'(m_ir >> 11) & 32'h1f);
    chk("rs",       32'(rs),       32'(m_ir >> 8)  & 32'h7);
    chk("rt",       32'(rt),       32'(m_ir >> 5)  & 32'h7);
    chk("rd",       32'(rd),       32'(m_ir >> 2)  & 32'h7);
    chk("funct",    32'(funct),    32'(m_ir)       & 32'h3);
    chk("imm",      32'(imm),      32'(m_ir)       & 32'h1f);
    chk("long_imm", 32'(long_imm), 32'(m_ir)       & 32'hff);
    chk("address",  32'(address),  32'(m_ir)       & 32'h7ff);
  endtask

  // One clock: drive inputs, check mem_ready mid-cycle, advance the model, check state after the edge.
  task automatic step(input logic mv, input logic [15:0] md, input logic iw, input logic fl,
                      input logic pw, input logic [15:0] pn, input logic r);
    logic        rdy;
    logic [15:0] old_pc;
    rst       = r;
    mem_valid = mv;
    mem_data  = md;
    ir_write  = iw;
    flush     = fl;
    pc_write  = pw;
    pc_next   = pn;
    @(negedge clk);
    rdy = (q.size() < DEPTH) && !fl;
    chk("mem_ready", 32'(mem_ready), 32'(rdy));
    old_pc = m_pc;
    if (r) begin
      model_reset();
    end else begin
      if (pw) m_pc = pn;
      if (fl) begin
        q.delete();
        m_irv = 1'b0;
        m_fpc = pw ? pn : old_pc;
      end else begin
        if (iw) begin
          if (q.size() > 0) begin
            m_ir    = q.pop_front();
            m_irv   = 1'b1;
            m_stall = 1'b0;
          end else begin
            m_stall = 1'b1;
          end
        end
        if (mv && rdy) begin
          q.push_back(md);
          m_fpc = m_fpc + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_data = '0; ir_write = 1'b0;
    flush = 1'b0; pc_write = 1'b0; pc_next = '0;
    @(posedge clk);
    #1;
    model_reset();
    check_state();

    // Two pushes, then pop the first and check its decoded fields against hand-derived values.
    step(1, 16'h8A5E, 0, 0, 0, 16'h0, 0);
    step(1, 16'h1234, 0, 0, 0, 16'h0, 0);
    chk("fetch_pc_after_2", 32'(fetch_pc), 32'h2);
    step(0, 16'h0, 1, 0, 0, 16'h0, 0);
    step(0, 16'h0, 0, 0, 0, 16'h0, 0);
    chk("op_8a5e",       32'(op),       32'h11);
    chk("rs_8a5e",       32'(rs),       32'h2);
    chk("rt_8a5e",       32'(rt),       32'h2);
    chk("rd_8a5e",       32'(rd),       32'h7);
    chk("funct_8a5e",    32'(funct),    32'h2);
    chk("imm_8a5e",      32'(imm),      32'h1E);
    chk("long_imm_8a5e", 32'(long_imm), 32'h5E);
    chk("address_8a5e",  32'(address),  32'h25E);
    chk("ir_valid_8a5e", 32'(ir_valid), 32'h1);

    // Fill to DEPTH, offer a fifth word, then pop while full with a word still offered.
    step(1, 16'hA001, 0, 0, 0, 16'h0, 0);
    step(1, 16'hA002, 0, 0, 0, 16'h0, 0);
    step(1, 16'hA003, 0, 0, 0, 16'h0, 0);
    step(1, 16'hBAD5, 0, 0, 0, 16'h0, 0);
    chk("full_ready_low", 32'(mem_ready), 32'h0);
    step(1, 16'hBAD6, 1, 0, 0, 16'h0, 0);
    chk("ready_after_full_pop", 32'(mem_ready), 32'h1);

    // Drain, stall on empty, push+ir_write on empty still stalls, then a pop clears the stall.
    step(0, 16'h0, 1, 0, 0, 16'h0, 0);
    step(0, 16'h0, 1, 0, 0, 16'h0, 0);
    step(0, 16'h0, 1, 0, 0, 16'h0, 0);
    step(0, 16'h0, 1, 0, 0, 16'h0, 0);
    chk("stall_on_empty", 32'(ir_stall), 32'h1);
    step(1, 16'hC0DE, 1, 0, 0, 16'h0, 0);
    step(0, 16'h0, 1, 0, 0, 16'h0, 0);
    chk("stall_cleared", 32'(ir_stall), 32'h0);
    chk("ir_after_stall", 32'(long_imm), 32'hDE);

    // Flush with a PC write and a concurrent push while three words are queued.
    step(1, 16'h1111, 0, 0, 0, 16'h0, 0);
    step(1, 16'h2222, 0, 0, 0, 16'h0, 0);
    step(1, 16'h3333, 0, 0, 0, 16'h0, 0);
    step(1, 16'h4444, 1, 1, 1, 16'h0040, 0);
    chk("flush_pc",       32'(pc),       32'h40);
    chk("flush_fetch_pc", 32'(fetch_pc), 32'h40);
    chk("flush_ir_valid", 32'(ir_valid), 32'h0);
    step(0, 16'h0, 1, 0, 0, 16'h0, 0);
    chk("flush_dropped_push", 32'(ir_stall), 32'h1);

    // Fetch address wrap, then reset asserted in the middle of a push.
    step(0, 16'h0, 0, 1, 1, 16'hFFFF, 0);
    step(1, 16'h5555, 0, 0, 0, 16'h0, 0);
    chk("fetch_pc_wrap", 32'(fetch_pc), 32'h0);
    step(1, 16'h6666, 1, 1, 1, 16'h1234, 1);
    chk("rst_pc",       32'(pc),       32'h0);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_op",       32'(op),       32'h0);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
           16'($urandom), 1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
